// File: rtl/ahb_latency_responder.sv
// ahb_latency_responder: AHB-Lite RAM subordinate that always answers OKAY
// and stretches each data phase by a programmable number of wait states.
module ahb_latency_responder #(
    parameter int AHBW        = 64,
    parameter int PA_BITS     = 56,
    parameter int DEPTH_WORDS = 1024,
    parameter int RAM_LATENCY = 0,
    parameter int BURST_EN    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               HSELRam,
    input  logic [PA_BITS-1:0] HADDR,
    input  logic               HWRITE,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    input  logic [AHBW-1:0]    HWDATA,
    input  logic [AHBW/8-1:0]  HWSTRB,
    output logic               HREADYRam,
    output logic               HRESPRam,
    output logic [AHBW-1:0]    HREADRam
);

    localparam int NB = AHBW / 8;
    localparam int AB = $clog2(NB);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = (RAM_LATENCY > 0) ? $clog2(RAM_LATENCY + 1) : 1;
    localparam logic [CW-1:0] LAT = CW'(RAM_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DATA
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_hready;
    logic            r_write;
    logic [IW-1:0]   r_idx;
    logic [AHBW-1:0] r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_seq;
    logic [CW-1:0]   w_wcnt;
    logic [IW-1:0]   w_idx;
    logic            w_commit;
    logic            w_rd_en;
    logic            w_unused;

    assign w_accept = HSELRam & HREADY & HTRANS[1];
    assign w_seq    = (HTRANS == 2'b11);
    assign w_wcnt   = (w_seq && (BURST_EN != 0)) ? '0 : LAT;
    assign w_idx    = HADDR[AB +: IW];
    assign w_commit = (r_state == S_DATA) && r_write && !reset;
    assign w_rd_en  = (r_state == S_DATA) && !r_write;
    assign w_unused = ^{HBURST, HADDR};

    // A new address phase may overlap the DATA cycle of the previous beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hready <= 1'b1;
            r_write  <= 1'b0;
            r_idx    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DATA: begin
                    if (w_accept) begin
                        r_idx   <= w_idx;
                        r_write <= HWRITE;
                        if (w_wcnt != '0) begin
                            r_state  <= S_WAIT;
                            r_cnt    <= w_wcnt;
                            r_hready <= 1'b0;
                        end else begin
                            r_state  <= S_DATA;
                            r_cnt    <= '0;
                            r_hready <= 1'b1;
                        end
                    end else begin
                        r_state  <= S_IDLE;
                        r_hready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt <= CW'(1)) begin
                        r_state  <= S_DATA;
                        r_cnt    <= '0;
                        r_hready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= '0;
                    r_hready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < NB; b++) begin
                if (HWSTRB[b]) begin
                    r_mem[r_idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
        end
    end

    assign HREADYRam = r_hready;
    assign HRESPRam  = 1'b0;
    assign HREADRam  = w_rd_en ? r_mem[r_idx] : '0;

endmodule

// File: tb/tb_ahb_latency_responder.sv
// tb_ahb_latency_responder: directed vector table plus hand sequences
// across three latency/burst configurations of the responder.
module tb_ahb_latency_responder;

    logic        clk;
    logic        reset;
    logic [2:0]  sel;
    logic [55:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [63:0] HWDATA;
    logic [7:0]  HWSTRB;
    logic        hrdy  [3];
    logic        hresp [3];
    logic [63:0] rdata [3];

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;
    int resp_bad = 0;

    typedef struct {
        int          d;
        logic        wr;
        logic [55:0] addr;
        int          n;
        logic [63:0] wd;
        logic [7:0]  st;
        logic [63:0] exp;
        int          c0;
        int          cs;
    } vec_t;

    vec_t vt [16];

    // d0: no waits; d1: 3 waits, bursts free; d2: 3 waits on every beat
    ahb_latency_responder #(.RAM_LATENCY(0), .BURST_EN(1)) u_d0 (
        .clk(clk), .reset(reset), .HSELRam(sel[0]), .HADDR(HADDR),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HBURST(HBURST),
        .HREADY(hrdy[0]), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HREADYRam(hrdy[0]), .HRESPRam(hresp[0]), .HREADRam(rdata[0])
    );
    ahb_latency_responder #(.RAM_LATENCY(3), .BURST_EN(1)) u_d1 (
        .clk(clk), .reset(reset), .HSELRam(sel[1]), .HADDR(HADDR),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HBURST(HBURST),
        .HREADY(hrdy[1]), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HREADYRam(hrdy[1]), .HRESPRam(hresp[1]), .HREADRam(rdata[1])
    );
    ahb_latency_responder #(.RAM_LATENCY(3), .BURST_EN(0)) u_d2 (
        .clk(clk), .reset(reset), .HSELRam(sel[2]), .HADDR(HADDR),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HBURST(HBURST),
        .HREADY(hrdy[2]), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HREADYRam(hrdy[2]), .HRESPRam(hresp[2]), .HREADRam(rdata[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hresp[0] !== 1'b0 || hresp[1] !== 1'b0 || hresp[2] !== 1'b0)
            resp_bad++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int d, input logic wr,
                                input logic [55:0] a, input int n,
                                input logic [63:0] wd, input logic [7:0] st,
                                input logic [63:0] exp, input int c0,
                                input int cs);
        vec_t v;
        v.d = d; v.wr = wr; v.addr = a; v.n = n; v.wd = wd;
        v.st = st; v.exp = exp; v.c0 = c0; v.cs = cs;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic wait_rdy(input int d, input int idx);
        int g;
        g = 0;
        while (hrdy[d] !== 1'b1 && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        chk("rdy_timeout", idx, 64'(g >= 40), 64'd0);
    endtask

    // Runs one single or INCR burst with pipelined address phases.
    task automatic xfer(input vec_t v, input int idx);
        int          cyc;
        int          v0;
        logic [63:0] rd;
        sel = '0;
        sel[v.d] = 1'b1;
        HADDR  = v.addr;
        HWRITE = v.wr;
        HTRANS = 2'b10;
        HBURST = (v.n > 1) ? 3'b011 : 3'b000;
        @(posedge clk); #1;
        for (int i = 0; i < v.n; i++) begin
            HWDATA = v.wd + 64'(i);
            HWSTRB = v.st;
            if (i < v.n - 1) begin
                HADDR  = v.addr + 56'(8 * (i + 1));
                HTRANS = 2'b11;
            end else begin
                HTRANS = 2'b00;
            end
            cyc = 1;
            v0  = viol;
            while (hrdy[v.d] !== 1'b1 && cyc < 40) begin
                if (rdata[v.d] !== 64'd0) viol++;
                @(posedge clk); #1;
                cyc++;
            end
            rd = rdata[v.d];
            chk("beat_cycles", idx * 10 + i, 64'(cyc),
                64'((i == 0) ? v.c0 : v.cs));
            chk("wait_rdata_zero", idx * 10 + i, 64'(viol - v0), 64'd0);
            chk("rdata", idx * 10 + i, rd,
                v.wr ? 64'd0 : v.exp + 64'(i));
            @(posedge clk); #1;
        end
        sel = '0;
    endtask

    // Write then read the same word back-to-back with overlapped phases.
    task automatic raw(input int d, input logic [55:0] a,
                       input logic [63:0] data, input int idx);
        sel = '0;
        sel[d] = 1'b1;
        HADDR  = a;
        HWRITE = 1'b1;
        HTRANS = 2'b10;
        HBURST = 3'b000;
        @(posedge clk); #1;
        HWDATA = data;
        HWSTRB = 8'hFF;
        HWRITE = 1'b0;
        wait_rdy(d, idx);
        @(posedge clk); #1;
        HTRANS = 2'b00;
        wait_rdy(d, idx);
        chk("raw_rdata", idx, rdata[d], data);
        @(posedge clk); #1;
        sel = '0;
    endtask

    initial begin
        reset  = 1'b1;
        sel    = '0;
        HADDR  = '0;
        HWRITE = 1'b0;
        HTRANS = 2'b00;
        HBURST = 3'b000;
        HWDATA = '0;
        HWSTRB = '0;

        vt[0]  = mk(0, 1, 56'h100, 1, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 1, 1);
        vt[1]  = mk(0, 0, 56'h100, 1, 0, 0, 64'hDEADBEEF_CAFEF00D, 1, 1);
        vt[2]  = mk(1, 1, 56'h200, 4, 64'h01010101_00000000, 8'hFF, 0, 4, 1);
        vt[3]  = mk(1, 0, 56'h200, 4, 0, 0, 64'h01010101_00000000, 4, 1);
        vt[4]  = mk(2, 1, 56'h200, 4, 64'h02020202_00000000, 8'hFF, 0, 4, 4);
        vt[5]  = mk(2, 0, 56'h200, 4, 0, 0, 64'h02020202_00000000, 4, 4);
        vt[6]  = mk(1, 0, 56'h200, 1, 0, 0, 64'h01010101_00000000, 4, 4);
        vt[7]  = mk(0, 1, 56'h300, 1, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 0, 1, 1);
        vt[8]  = mk(0, 1, 56'h300, 1, 64'h11111111_11111111, 8'h0F, 0, 1, 1);
        vt[9]  = mk(0, 0, 56'h300, 1, 0, 0, 64'hFFFFFFFF_11111111, 1, 1);
        vt[10] = mk(0, 1, 56'h300, 1, 64'h22222222_22222222, 8'h00, 0, 1, 1);
        vt[11] = mk(0, 0, 56'h300, 1, 0, 0, 64'hFFFFFFFF_11111111, 1, 1);
        vt[12] = mk(0, 1, 56'h2000, 1, 64'h5A5A0000_12345678, 8'hFF, 0, 1, 1);
        vt[13] = mk(0, 0, 56'h0, 1, 0, 0, 64'h5A5A0000_12345678, 1, 1);
        vt[14] = mk(1, 0, 56'h2200, 1, 0, 0, 64'h01010101_00000000, 4, 4);
        vt[15] = mk(1, 1, 56'h40, 1, 64'h01234567_89ABCDEF, 8'hFF, 0, 4, 4);

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_hready", d, 64'(hrdy[d]), 64'd1);
            chk("reset_hresp", d, 64'(hresp[d]), 64'd0);
            chk("reset_rdata", d, rdata[d], 64'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) xfer(vt[i], i);

        raw(0, 56'h500, 64'h0F0E0D0C_0B0A0908, 100);
        raw(1, 56'h508, 64'h1122AABB_3344CCDD, 101);

        // Abort a write in its wait states; memory must keep the old word.
        sel    = 3'b010;
        HADDR  = 56'h40;
        HWRITE = 1'b1;
        HTRANS = 2'b10;
        HBURST = 3'b000;
        @(posedge clk); #1;
        HWDATA = 64'hBADBADBA_DBADBAD0;
        HWSTRB = 8'hFF;
        HTRANS = 2'b00;
        chk("wait_low_before_reset", 200, 64'(hrdy[1]), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("hready_after_reset", 201, 64'(hrdy[1]), 64'd1);
        @(posedge clk); #1;
        chk("hready_idle_after_reset", 202, 64'(hrdy[1]), 64'd1);
        chk("rdata_idle_after_reset", 203, rdata[1], 64'd0);
        sel = '0;
        xfer(mk(1, 0, 56'h40, 1, 0, 0, 64'h01234567_89ABCDEF, 4, 4), 204);

        chk("hresp_nonzero_cycles", 300, 64'(resp_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
